// File: rtl/cve2_mac_accumulate_stage.sv
// MAC accumulate stage: captures the accumulator addend at MAC start, waits
// for the multiplier product, adds the two with overflow detection and
// optional saturation, then holds the result until writeback accepts it.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no operation in flight; start_i captures addend and sign mode
// WAIT_MUL | addend held; waiting for the single-cycle mul_valid_i pulse
// ADD      | product and addend summed, result/overflow registered
// RESP     | valid_o high, result held until ready_i (or flush/reset)
module cve2_mac_accumulate_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] acc_operand_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] mul_result_i,
  input  logic             mul_valid_i,
  input  logic             flush_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MUL = 2'd1;
  localparam logic [1:0] ADD      = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] prod_q;
  logic             signed_q;

  logic [WIDTH:0]   sum;
  logic             ovf_d;
  logic [WIDTH-1:0] res_d;

  // Next-state selection; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_i)     state_d = WAIT_MUL;
      WAIT_MUL: if (mul_valid_i) state_d = ADD;
      ADD:                       state_d = RESP;
      RESP:     if (ready_i)     state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Sum with carry bit, overflow detection and optional clamping.
  always_comb begin
    sum = {1'b0, prod_q} + {1'b0, acc_q};
    if (signed_q) begin
      ovf_d = (prod_q[WIDTH-1] == acc_q[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
    end else begin
      ovf_d = sum[WIDTH];
    end
    res_d = sum[WIDTH-1:0];
    if (SATURATE && ovf_d) begin
      if (!signed_q)             res_d = UMAX;
      else if (acc_q[WIDTH-1])   res_d = SMIN;
      else                       res_d = SMAX;
    end
  end

  // State, handshake outputs and data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      prod_q     <= '0;
      signed_q   <= 1'b0;
      result_o   <= '0;
      overflow_o <= 1'b0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d != IDLE);
      valid_o <= (state_d == RESP);

      if (!flush_i && state_q == IDLE && start_i) begin
        acc_q    <= acc_operand_i;
        signed_q <= signed_i;
      end

      if (!flush_i && state_q == WAIT_MUL && mul_valid_i) begin
        prod_q <= mul_result_i;
      end

      // overflow_o only carries meaning alongside valid_o, so it is cleared
      // whenever the stage is not heading into (or staying in) RESP.
      if (!flush_i && state_q == ADD) begin
        result_o   <= res_d;
        overflow_o <= ovf_d;
      end else if (state_d != RESP) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule
